mannix_ddr_rd_ctrl: RTL and testbench
=====================================

MANNIX_DDR_RD_CTRL -- requirements
Module: mannix_ddr_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, DDR and client read-data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, return-data buffer entries (power of 2, >=2).
REQ-003 SHALL have ports clk, input, 1, the single clock; all logic is on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-high (1 = reset), sampled on clk rising edge.
REQ-005 SHALL have ports req_valid (in, 1) and req_ready (out, 1): burst request handshake from mannix_mem_farm.
REQ-006 SHALL have ports req_addr (in, 32), first DDR byte address, and req_len (in, 8), number of words.
REQ-007 SHALL have ports ddr_rd_valid (out, 1), ddr_rd_ready (in, 1) and ddr_rd_addr (out, 32): DDR read command channel.
REQ-008 SHALL have ports ddr_rdata_valid (in, 1) and ddr_rdata (in, DATA_WIDTH): DDR return data, in order, no backpressure.
REQ-009 SHALL have ports out_valid (out, 1), out_ready (in, 1) and out_data (out, DATA_WIDTH): data stream to the client.
REQ-010 SHALL have port done (out, 1): one-cycle pulse at burst completion.

Function
REQ-011 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-012 IDLE: req_ready=1; on req_valid&&req_ready, latch addr/len; len!=0 -> ISSUE; len==0 -> pulse done next cycle, stay IDLE, no DDR command.
REQ-013 req_ready SHALL be 1 only in IDLE; requests arriving in other states wait (not dropped).
REQ-014 ISSUE: ddr_rd_valid=1 only when credit available: fifo_count + outstanding < FIFO_DEPTH.
REQ-015 Each command accepted (ddr_rd_valid&&ddr_rd_ready) SHALL increment ddr_rd_addr by 4 and decrement remaining; first command uses req_addr.
REQ-016 ddr_rd_addr SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-017 ddr_rd_valid/ddr_rd_addr SHALL stay stable while ddr_rd_valid=1 and ddr_rd_ready=0.
REQ-018 When the last command is accepted, SHALL go to DRAIN next cycle; ddr_rd_valid=0 in DRAIN.
REQ-019 outstanding SHALL +1 per accepted command, -1 per ddr_rdata_valid; both in one cycle -> unchanged.
REQ-020 Each ddr_rdata_valid SHALL write ddr_rdata to the FIFO; credit rule guarantees no overflow.
REQ-021 out_valid = FIFO not empty; out_data = FIFO head (first-word fall-through); pop on out_valid&&out_ready.
REQ-022 Simultaneous push and pop SHALL both occur, count unchanged, including when FIFO full or holding one entry.
REQ-023 DRAIN: when outstanding==0 and FIFO empty after pop, SHALL pulse done for one cycle and return to IDLE.
REQ-024 ddr_rdata_valid with outstanding==0 is illegal; data SHALL be discarded, counters unchanged.
REQ-025 Data order at out_data SHALL equal command order; exactly req_len words per burst.

Reset
REQ-026 While rst_n=1: state IDLE, req_ready=0, ddr_rd_valid=0, ddr_rd_addr=0, out_valid=0, out_data=0, done=0, FIFO empty, counters 0.
REQ-027 First cycle after rst_n falls, req_ready=1.
REQ-028 Reset mid-burst SHALL abort it without done; DDR data returning after reset SHALL be discarded (REQ-024).

Verification
REQ-029 req_addr=0x1000, len=4, ddr_rd_ready=1, rdata after 3 cycles, out_ready=1 -> commands 0x1000,0x1004,0x1008,0x100C on consecutive cycles; 4 words out in order; single done.
REQ-030 len=20, out_ready=0 -> exactly 8 commands issued then ddr_rd_valid=0; raising out_ready resumes issue; 20 words total, done once.
REQ-031 req_addr=0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-032 len=0 -> no ddr_rd_valid, done one cycle after handshake, req_ready stays 1.
REQ-033 ddr_rd_ready toggling randomly, out_ready random -> address held stable while stalled; no FIFO overflow; data matches order.
REQ-034 rst_n=1 after 2 of 6 commands -> all outputs at reset values next cycle; no done; subsequent len=2 burst completes normally.

Source files
------------

// File: rtl/mannix_ddr_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mannix_ddr_rd_ctrl : credit-limited DDR burst reader with return-data FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
module mannix_ddr_rd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [7:0]            req_len,
  output logic                  ddr_rd_valid,
  input  logic                  ddr_rd_ready,
  output logic [31:0]           ddr_rd_addr,
  input  logic                  ddr_rdata_valid,
  input  logic [DATA_WIDTH-1:0] ddr_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] c_depth = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_addr;
  logic [7:0]            r_remaining;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_outstanding_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_credit;
  logic                  w_req_fire;
  logic                  w_cmd_fire;
  logic                  w_push;
  logic                  w_pop;

  // A command is only issued if its data is guaranteed a FIFO slot on return.
  assign w_credit     = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_depth;

  assign req_ready    = (r_state == IDLE) && !rst_n;
  assign ddr_rd_valid = (r_state == ISSUE) && w_credit && !rst_n;
  assign ddr_rd_addr  = r_addr;
  assign out_valid    = (r_count != '0) && !rst_n;
  assign out_data     = out_valid ? r_mem[r_rd_ptr] : '0;
  assign done         = r_done;

  assign w_req_fire   = req_valid && req_ready;
  assign w_cmd_fire   = ddr_rd_valid && ddr_rd_ready;
  // Data with nothing in flight (e.g. after an aborted burst) is dropped.
  assign w_push       = ddr_rdata_valid && (r_outstanding != '0);
  assign w_pop        = out_valid && out_ready;

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_cmd_fire && !w_push) begin
      w_outstanding_nxt = r_outstanding + CNT_W'(1);
    end else if (!w_cmd_fire && w_push) begin
      w_outstanding_nxt = r_outstanding - CNT_W'(1);
    end

    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_fire) begin
          if (req_len != 8'd0) begin
            w_state_nxt = ISSUE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (w_cmd_fire && (r_remaining == 8'd1)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((w_outstanding_nxt == '0) && (w_count_nxt == '0)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_done        <= w_done_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_count       <= w_count_nxt;
      if (w_req_fire) begin
        r_addr      <= req_addr;
        r_remaining <= req_len;
      end else if (w_cmd_fire) begin
        r_addr      <= r_addr + 32'd4;
        r_remaining <= r_remaining - 8'd1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && w_push) begin
      r_mem[r_wr_ptr] <= ddr_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mannix_ddr_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for mannix_ddr_rd_ctrl: a DDR model returns address-derived
// words; expected commands/data are queued at request time and popped on output.
module tb_mannix_ddr_rd_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic [7:0]    req_len = '0;
  logic          ddr_rd_valid;
  logic          ddr_rd_ready = 1'b0;
  logic [31:0]   ddr_rd_addr;
  logic          ddr_rdata_valid = 1'b0;
  logic [DW-1:0] ddr_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          done;

  mannix_ddr_rd_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .ddr_rd_valid(ddr_rd_valid), .ddr_rd_ready(ddr_rd_ready), .ddr_rd_addr(ddr_rd_addr),
    .ddr_rdata_valid(ddr_rdata_valid), .ddr_rdata(ddr_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rand_mode = 1'b0;
  bit fix_ddr_ready = 1'b1;
  bit fix_out_ready = 1'b1;
  int lat = 3;

  logic [31:0]   exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            exp_done = 0;
  logic [DW-1:0] pend_data[$];
  int            pend_due[$];
  int            last_due = 0;

  int vectors = 0, miscompares = 0;
  int hs_cnt = 0, hs_cyc = 0, acc_total = 0, done_cnt = 0, done_cyc = 0;
  int acc_count = 0, pop_count = 0;
  int acc_cyc[$];
  bit stall_pend = 1'b0;
  logic [31:0] stall_addr = '0;

  function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives DDR/client inputs for the coming edge, then scores that edge's handshakes.
  always @(negedge clk) begin : mon
    logic [31:0] a;
    int due;
    if (rand_mode) begin
      ddr_rd_ready = ($urandom_range(0, 1) == 1);
      out_ready    = ($urandom_range(0, 9) < 6);
    end else begin
      ddr_rd_ready = fix_ddr_ready;
      out_ready    = fix_out_ready;
    end
    if (pend_due.size() != 0 && pend_due[0] <= cyc + 1) begin
      ddr_rdata_valid = 1'b1;
      ddr_rdata       = pend_data.pop_front();
      void'(pend_due.pop_front());
    end else begin
      ddr_rdata_valid = 1'b0;
    end

    if (rst_n) begin
      exp_addr.delete();
      exp_data.delete();
      exp_done   = 0;
      stall_pend = 1'b0;
      acc_count  = 0;
      pop_count  = 0;
    end else begin
      if (stall_pend) begin
        check("stall_valid_held", {63'd0, ddr_rd_valid}, 64'd1);
        check("stall_addr_held", {32'd0, ddr_rd_addr}, {32'd0, stall_addr});
      end
      stall_pend = ddr_rd_valid && !ddr_rd_ready;
      stall_addr = ddr_rd_addr;

      if (req_valid && req_ready) begin
        for (int i = 0; i < int'(req_len); i++) begin
          a = req_addr + 32'(4 * i);
          exp_addr.push_back(a);
          exp_data.push_back(mem_word(a));
        end
        exp_done++;
        hs_cnt++;
        hs_cyc = cyc;
      end

      if (ddr_rd_valid && ddr_rd_ready) begin
        check("cmd_expected", {63'd0, exp_addr.size() != 0}, 64'd1);
        if (exp_addr.size() != 0) check("cmd_addr", {32'd0, ddr_rd_addr}, {32'd0, exp_addr.pop_front()});
        due = cyc + 1 + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_data.push_back(mem_word(ddr_rd_addr));
        pend_due.push_back(due);
        acc_total++;
        acc_count++;
        acc_cyc.push_back(cyc);
      end

      if (out_valid && out_ready) begin
        check("out_expected", {63'd0, exp_data.size() != 0}, 64'd1);
        if (exp_data.size() != 0) check("out_data", {32'd0, out_data}, {32'd0, exp_data.pop_front()});
        pop_count++;
      end

      if (ddr_rd_valid && ddr_rd_ready)
        check("credit_in_flight", {63'd0, (acc_count - pop_count) <= DEPTH}, 64'd1);

      if (done) begin
        check("done_expected", {63'd0, exp_done != 0}, 64'd1);
        if (exp_done != 0) exp_done--;
        check("done_after_all_data", 64'(exp_data.size() + exp_addr.size()), 64'd0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [7:0] l);
    int start;
    start = hs_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i < 300 && hs_cnt == start; i++) begin
      @(posedge clk); #1;
    end
    check("req_accepted", {63'd0, hs_cnt != start}, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int bound);
    for (int i = 0; i < bound && done_cnt == start; i++) @(posedge clk);
    check("done_seen", {63'd0, done_cnt != start}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, base, b0;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_ddr_rd_valid", {63'd0, ddr_rd_valid}, 64'd0);
    check("rst_ddr_rd_addr", {32'd0, ddr_rd_addr}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Basic 4-word burst, fixed 3-cycle latency, back-to-back commands.
    fix_ddr_ready = 1'b1; fix_out_ready = 1'b1; lat = 3;
    b0 = acc_cyc.size();
    start = done_cnt;
    issue(32'h0000_1000, 8'd4);
    wait_done(start, 200);
    for (int i = 1; i < 4; i++)
      check("cmd_consecutive", 64'(acc_cyc[b0 + i] - acc_cyc[b0]), 64'(i));

    // Address wrap at the top of the 32-bit space.
    start = done_cnt;
    issue(32'hFFFF_FFF8, 8'd3);
    wait_done(start, 200);

    // Zero-length request.
    start = done_cnt;
    base  = acc_total;
    issue(32'h0000_5000, 8'd0);
    @(negedge clk);
    check("len0_done_pulse", {63'd0, done}, 64'd1);
    check("len0_req_ready", {63'd0, req_ready}, 64'd1);
    check("len0_no_cmd_valid", {63'd0, ddr_rd_valid}, 64'd0);
    wait_done(start, 20);
    check("len0_done_latency", 64'(done_cyc - hs_cyc), 64'd1);
    check("len0_no_cmds", 64'(acc_total - base), 64'd0);

    // Credit limit with the client stalled.
    fix_out_ready = 1'b0;
    start = done_cnt;
    base  = acc_total;
    issue(32'h0000_4000, 8'd20);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("credit_stop_cmds", 64'(acc_total - base), 64'(DEPTH));
    check("credit_stop_valid", {63'd0, ddr_rd_valid}, 64'd0);
    @(posedge clk); #1;
    fix_out_ready = 1'b1;
    wait_done(start, 400);
    check("credit_total_cmds", 64'(acc_total - base), 64'd20);

    // Randomised handshakes, latencies, lengths and addresses.
    rand_mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(1, 6);
      a   = $urandom & 32'hFFFF_FFFC;
      if (k % 4 == 0) a = 32'hFFFF_FF00 | (a & 32'h0000_00FC);
      start = done_cnt;
      issue(a, 8'($urandom_range(1, 40)));
      wait_done(start, 3000);
    end
    rand_mode = 1'b0;

    // Reset in the middle of a burst.
    fix_ddr_ready = 1'b1; fix_out_ready = 1'b0; lat = 4;
    start = done_cnt;
    base  = acc_total;
    issue(32'h0000_3000, 8'd6);
    for (int i = 0; i < 50 && (acc_total - base) < 2; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cmds", 64'(acc_total - base), 64'd2);
    check("abort_req_ready", {63'd0, req_ready}, 64'd0);
    check("abort_ddr_rd_valid", {63'd0, ddr_rd_valid}, 64'd0);
    check("abort_ddr_rd_addr", {32'd0, ddr_rd_addr}, 64'd0);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_out_data", {32'd0, out_data}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    fix_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("discard_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'(start));
    start = done_cnt;
    issue(32'h0000_2000, 8'd2);
    wait_done(start, 200);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(exp_data.size() + exp_addr.size()), 64'd0);
    check("done_balance", 64'(exp_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
